// File: rtl/segs_display_arbiter.sv
// Round-robin owner of the six-digit seven-segment display shared by requesters A and B.
// A minimum hold time applies per owner, and one blanked cycle is inserted on every handover.
module segs_display_arbiter #(
    parameter int HOLD_CYCLES = 1000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqA,
    input  logic [23:0] DataA,
    input  logic [5:0]  EnA,
    input  logic        ReqB,
    input  logic [23:0] DataB,
    input  logic [5:0]  EnB,
    output logic        GrantA,
    output logic        GrantB,
    output logic [23:0] Data,
    output logic [5:0]  DisplayEnables
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SWITCH = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          last_b_q;
    logic          grant_a_q;
    logic          grant_b_q;
    logic [23:0]   data_q;
    logic [5:0]    en_q;

    logic any_req;
    logic win_b;
    logic own_req;
    logic oth_req;

    // On a tie the requester that did not own the display last time wins.
    assign any_req = ReqA | ReqB;
    assign win_b   = ReqB & (~ReqA | ~last_b_q);
    assign own_req = last_b_q ? ReqB : ReqA;
    assign oth_req = last_b_q ? ReqA : ReqB;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_b_q  <= 1'b1;
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
            data_q    <= 24'h0;
            en_q      <= 6'h0;
        end else begin
            case (state_q)
                IDLE, SWITCH: begin
                    if (any_req) begin
                        state_q   <= HOLD;
                        cnt_q     <= '0;
                        last_b_q  <= win_b;
                        grant_a_q <= ~win_b;
                        grant_b_q <= win_b;
                        data_q    <= win_b ? DataB : DataA;
                        en_q      <= win_b ? EnB : EnA;
                    end else begin
                        state_q   <= IDLE;
                        grant_a_q <= 1'b0;
                        grant_b_q <= 1'b0;
                        en_q      <= 6'h0;
                    end
                end
                HOLD: begin
                    if (own_req && (!oth_req || cnt_q != CNT_MAX)) begin
                        data_q <= last_b_q ? DataB : DataA;
                        en_q   <= last_b_q ? EnB : EnA;
                        if (cnt_q != CNT_MAX)
                            cnt_q <= cnt_q + 1'b1;
                    end else begin
                        // Blank for one cycle before anyone else may own the display.
                        state_q   <= oth_req ? SWITCH : IDLE;
                        grant_a_q <= 1'b0;
                        grant_b_q <= 1'b0;
                        en_q      <= 6'h0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    grant_a_q <= 1'b0;
                    grant_b_q <= 1'b0;
                    en_q      <= 6'h0;
                end
            endcase
        end
    end

    assign GrantA         = grant_a_q;
    assign GrantB         = grant_b_q;
    assign Data           = data_q;
    assign DisplayEnables = en_q;

endmodule

// File: tb/tb_segs_display_arbiter.sv
// Scoreboard bench for segs_display_arbiter: one instance with an 8-cycle hold and one with a 1-cycle hold.
module tb_segs_display_arbiter;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;

    logic        ReqA8 = 1'b0, ReqB8 = 1'b0;
    logic [23:0] DataA8 = 24'h0, DataB8 = 24'h0;
    logic [5:0]  EnA8 = 6'h0, EnB8 = 6'h0;
    logic        GrantA8, GrantB8;
    logic [23:0] Data8;
    logic [5:0]  En8;

    logic        ReqA1 = 1'b0, ReqB1 = 1'b0;
    logic [23:0] DataA1 = 24'h0, DataB1 = 24'h0;
    logic [5:0]  EnA1 = 6'h0, EnB1 = 6'h0;
    logic        GrantA1, GrantB1;
    logic [23:0] Data1;
    logic [5:0]  En1;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];

    always #5 Clock = ~Clock;

    segs_display_arbiter #(.HOLD_CYCLES(8)) u_dut8 (
        .Clock(Clock), .Reset(Reset),
        .ReqA(ReqA8), .DataA(DataA8), .EnA(EnA8),
        .ReqB(ReqB8), .DataB(DataB8), .EnB(EnB8),
        .GrantA(GrantA8), .GrantB(GrantB8), .Data(Data8), .DisplayEnables(En8)
    );

    segs_display_arbiter #(.HOLD_CYCLES(1)) u_dut1 (
        .Clock(Clock), .Reset(Reset),
        .ReqA(ReqA1), .DataA(DataA1), .EnA(EnA1),
        .ReqB(ReqB1), .DataB(DataB1), .EnB(EnB1),
        .GrantA(GrantA1), .GrantB(GrantB1), .Data(Data1), .DisplayEnables(En1)
    );

    function automatic logic [31:0] pk(input logic ga, input logic gb,
                                       input logic [5:0] en, input logic [23:0] d);
        return {ga, gb, en, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Drive one cycle of requests to instance d, queue the expected post-edge outputs, then compare.
    task automatic step(input int d, input logic ra, input logic rb, input logic [31:0] exp,
                        input string tag);
        logic [31:0] got;
        if (d == 0) begin ReqA8 = ra; ReqB8 = rb; end
        else        begin ReqA1 = ra; ReqB1 = rb; end
        exp_q.push_back(exp);
        @(posedge Clock);
        #1;
        got = (d == 0) ? pk(GrantA8, GrantB8, En8, Data8) : pk(GrantA1, GrantB1, En1, Data1);
        chk(tag, got, exp_q.pop_front());
        chk({tag, "_excl"}, {31'h0, got[31] & got[30]}, 32'h0);
        chk({tag, "_engate"}, {31'h0, (got[29:24] != 6'h0) && !(got[31] | got[30])}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] last_d;
        int m;

        #1;
        chk("rst8", pk(GrantA8, GrantB8, En8, Data8), 32'h0);
        chk("rst1", pk(GrantA1, GrantB1, En1, Data1), 32'h0);
        @(posedge Clock); #1;
        Reset = 1'b0;

        // Single requester, then release, then the other requester.
        DataA8 = 24'h543210; EnA8 = 6'h3F;
        DataB8 = 24'hABCDEF; EnB8 = 6'h15;
        step(0, 1, 0, pk(1, 0, 6'h3F, 24'h543210), "grantA");
        step(0, 0, 0, pk(0, 0, 6'h0, 24'h543210), "dropA_idle");
        step(0, 0, 1, pk(0, 1, 6'h15, 24'hABCDEF), "grantB");
        step(0, 0, 0, pk(0, 0, 6'h0, 24'hABCDEF), "dropB_idle");

        // A owns; B arrives at cnt=2 and waits out the full hold.
        step(0, 1, 0, pk(1, 0, EnA8, DataA8), "holdA_grant");
        for (int k = 1; k <= 7; k++) begin
            if (k == 4) begin DataA8 = 24'h0A0B0C; EnA8 = 6'h21; end
            step(0, 1, (k >= 3), pk(1, 0, EnA8, DataA8), $sformatf("holdA_%0d", k));
        end
        step(0, 1, 1, pk(0, 0, 6'h0, DataA8), "preempt_gap");
        step(0, 1, 1, pk(0, 1, EnB8, DataB8), "preempt_grantB");

        // Owner drops while the other requests: immediate switch.
        step(0, 1, 0, pk(0, 0, 6'h0, DataB8), "ownerdrop_gap");
        step(0, 1, 0, pk(1, 0, EnA8, DataA8), "ownerdrop_grantA");
        step(0, 0, 0, pk(0, 0, 6'h0, DataA8), "bothdrop_idle");

        // Asynchronous reset in the middle of a hold.
        step(0, 1, 0, pk(1, 0, EnA8, DataA8), "pre_rst_grant");
        step(0, 1, 0, pk(1, 0, EnA8, DataA8), "pre_rst_hold");
        #2;
        Reset = 1'b1;
        #1;
        chk("async_rst8", pk(GrantA8, GrantB8, En8, Data8), 32'h0);
        chk("async_rst1", pk(GrantA1, GrantB1, En1, Data1), 32'h0);
        ReqA8 = 1'b1; ReqB8 = 1'b1;
        @(posedge Clock); #1;
        chk("rst_held", pk(GrantA8, GrantB8, En8, Data8), 32'h0);
        Reset = 1'b0;

        // Both request out of reset: A first, then B after the hold, then A again.
        step(0, 1, 1, pk(1, 0, EnA8, DataA8), "tie_grantA");
        for (int k = 1; k <= 7; k++)
            step(0, 1, 1, pk(1, 0, EnA8, DataA8), $sformatf("tie_holdA_%0d", k));
        step(0, 1, 1, pk(0, 0, 6'h0, DataA8), "tie_gap1");
        step(0, 1, 1, pk(0, 1, EnB8, DataB8), "tie_grantB");
        for (int k = 1; k <= 7; k++)
            step(0, 1, 1, pk(0, 1, EnB8, DataB8), $sformatf("tie_holdB_%0d", k));
        step(0, 1, 1, pk(0, 0, 6'h0, DataB8), "tie_gap2");
        step(0, 1, 1, pk(1, 0, EnA8, DataA8), "tie_grantA2");
        step(0, 0, 0, pk(0, 0, 6'h0, DataA8), "tie_idle");

        // One-cycle hold: A, gap, B, gap, ...
        DataA1 = 24'hA1A1A1; EnA1 = 6'h0F;
        DataB1 = 24'hB2B2B2; EnB1 = 6'h30;
        last_d = 24'h0;
        for (int k = 1; k <= 12; k++) begin
            m = k % 4;
            if (m == 1) begin
                last_d = DataA1;
                step(1, 1, 1, pk(1, 0, EnA1, DataA1), $sformatf("h1_%0d", k));
            end else if (m == 3) begin
                last_d = DataB1;
                step(1, 1, 1, pk(0, 1, EnB1, DataB1), $sformatf("h1_%0d", k));
            end else begin
                step(1, 1, 1, pk(0, 0, 6'h0, last_d), $sformatf("h1_gap_%0d", k));
            end
        end
        step(1, 0, 0, pk(0, 0, 6'h0, last_d), "h1_idle");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
